tpu_top: RTL and testbench
==========================

// Module: tpu_top
// PURPOSE
//  Top level of the 4x4 TPU: INT8 matrix multiply C[m x n] = A[m x k] * B[k x n].
//  Holds three global buffers (GBUFF_A, GBUFF_B, GBUFF_OUT) and a 4x4
//  output-stationary systolic PE array, sequenced by a tiling FSM.
//  Host preloads A/B contents, pulses start, waits for done, then reads GBUFF_OUT.
// PARAMETERS
//  DATA_W      8    element width (unsigned)
//  ARRAY       4    PE array edge; also elements per buffer word
//  WORD_W      32   buffer word width (ARRAY*DATA_W)
//  GBUFF_DEPTH 256  words per global buffer
//  ACC_W       20   PE accumulator width
// PORTS
//  clk    in   1  rising-edge clock
//  rst    in   1  asynchronous reset, active-low
//  start  in   1  begin operation (level, sampled in IDLE)
//  m      in   4  rows of A / C, 1..15
//  k      in   4  cols of A = rows of B, 1..15
//  n      in   4  cols of B / C, 1..15
//  done   out  1  result complete in GBUFF_OUT
// BEHAVIOUR
//  - Buffers: instance names GBUFF_A/GBUFF_B/GBUFF_OUT, storage array 'gbuff'
//    [0:GBUFF_DEPTH-1][WORD_W-1:0]. Bench preloads and reads hierarchically.
//  - Buffer I/O: sync write, 1-cycle read latency. Not cleared by reset.
//  - Byte lane j = bits [8j+7:8j]. Lane 0 = [7:0] holds the lowest index.
//  - A layout: word rb*k+kk, lane j = A[4rb+j][kk]. Zero-padded past row m-1.
//  - B layout: word cb*k+kk, lane j = B[kk][4cb+j]. Zero-padded past col n-1.
//  - OUT layout: word r*ceil(n/4)+cb, lane j = C[r][4cb+j]. Lanes past col n-1 are written 0.
//  - Arithmetic: unsigned 8x8 products accumulated in ACC_W bits.
//    Stored value = acc[7:0] (mod 256 truncation).
//  - Reset: FSM=IDLE, done=0, PE accumulators=0, pipeline regs=0, counters=0.
//  - FSM: IDLE -> LOAD -> FEED -> DRAIN -> WRITE -> (next tile: LOAD | DONE).
//    IDLE: start=1 on a clock edge latches m,k,n and clears tile counters (rb=cb=0).
//    LOAD: clear PE accumulators, issue first A/B read addresses.
//    FEED: k cycles reading A word rb*k+kk and B word cb*k+kk.
//      A row j is skewed by j cycles; B column j is skewed by j cycles.
//    DRAIN: 2*ARRAY-1 cycles flush the skew, then output registers hold.
//    WRITE: up to ARRAY cycles, one OUT word per valid row 4rb+i < m.
//    Tile order: cb inner, rb outer, over ceil(m/4) x ceil(n/4) tiles.
//    DONE: done=1, held until reset. start ignored in DONE.
//  - done is registered and rises the cycle after the last OUT write.
//  - start deasserting mid-run has no effect. Inputs m,k,n are used only as latched.
//  - rst low mid-operation aborts immediately to IDLE with done=0.
//    Partial GBUFF_OUT contents are left as-is.
//  - Worst-case latency (m=n=k=15): < 16*(k+3*ARRAY+2) cycles; well under 1000.
//  - m,k,n = 0 are illegal. Behaviour is defined as: go directly to DONE, no writes.
// TESTING
//  1 m=k=n=4, A=identity, B=0x01..0x10 -> OUT[0..3] equals B rows, lane0=B[r][0]; done=1.
//  2 m=2,k=3,n=5, all A=B=1 -> each C=3. OUT[r*2+1] lanes1..3=0. Words 0..3 only.
//  3 m=k=n=1, A=0x0F, B=0x11 -> OUT[0]=32'h000000FF; done within 20 cycles.
//  4 m=k=n=4, all A=B=0xFF -> C=4*0xFE01 mod 256 = 0x04 in every lane.
//  5 m=8,k=4,n=12 random data -> 24 OUT words match a software model; 3 words per row.
//  6 assert rst low mid-FEED, then rerun test 1 -> done drops to 0; second run passes.

Source files
------------

// File: rtl/tpu_top.sv
// tpu_top: 4x4 output-stationary systolic INT8 matrix multiplier.
//   C[m x n] = A[m x k] * B[k x n], unsigned 8-bit elements, stored mod 256.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   start       level; sampled only in IDLE, latches m/k/n
//   m, k, n     matrix dimensions 1..15 (any zero goes straight to DONE)
//   done        registered; high the cycle after the last OUT write, held until reset
//   o_dbg_state current FSM state (debug observation)
// Handshake: there is no valid/ready pair; the host preloads GBUFF_A/GBUFF_B,
// holds start high until it leaves IDLE, then waits for done before reading GBUFF_OUT.

module tpu_gbuff #(
    parameter int DEPTH = 256,
    parameter int W     = 32,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    // Contents are deliberately not reset.
    logic [W-1:0] gbuff [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) gbuff[i_waddr] <= i_wdata;
        o_rdata <= gbuff[i_raddr];
    end
endmodule

module tpu_top #(
    parameter int DATA_W      = 8,
    parameter int ARRAY       = 4,
    parameter int WORD_W      = 32,
    parameter int GBUFF_DEPTH = 256,
    parameter int ACC_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] m,
    input  logic [3:0] k,
    input  logic [3:0] n,
    output logic       done,
    output logic [2:0] o_dbg_state
);
    localparam int AW = $clog2(GBUFF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t r_state, w_next;
    logic [3:0] r_m, r_k, r_n, r_rb, r_cb, r_cnt;
    logic       r_done;

    logic [AW-1:0]     w_mb, w_nb, w_row, w_col_base, w_kk;
    logic [AW-1:0]     w_a_raddr, w_b_raddr, w_out_waddr;
    logic [WORD_W-1:0] w_a_rdata, w_b_rdata, w_out_rdata, w_out_wdata;
    logic [WORD_W-1:0] w_a_word, w_b_word;
    logic              w_out_we, w_last_row, w_last_tile, w_unused_rd;

    logic [DATA_W-1:0] r_a_skew [ARRAY][ARRAY];
    logic [DATA_W-1:0] r_b_skew [ARRAY][ARRAY];
    logic [DATA_W-1:0] r_a_pipe [ARRAY][ARRAY];
    logic [DATA_W-1:0] r_b_pipe [ARRAY][ARRAY];
    logic [DATA_W-1:0] w_a_in   [ARRAY][ARRAY];
    logic [DATA_W-1:0] w_b_in   [ARRAY][ARRAY];
    logic [ACC_W-1:0]  r_acc    [ARRAY][ARRAY];

    // Tile counts: ceil(dim / ARRAY).
    assign w_mb       = AW'((r_m + ARRAY - 1) / ARRAY);
    assign w_nb       = AW'((r_n + ARRAY - 1) / ARRAY);
    assign w_row      = AW'(r_rb * ARRAY) + AW'(r_cnt);
    assign w_col_base = AW'(r_cb * ARRAY);

    assign w_last_row  = (r_cnt == 4'(ARRAY - 1)) || (w_row + AW'(1) >= AW'(r_m));
    assign w_last_tile = (AW'(r_cb) + AW'(1) >= w_nb) && (AW'(r_rb) + AW'(1) >= w_mb);

    // LOAD issues word 0; FEED cycle c consumes word c and issues word c+1,
    // hiding the one-cycle read latency.
    assign w_kk      = (r_state == S_LOAD) ? '0 : AW'(r_cnt) + AW'(1);
    assign w_a_raddr = AW'(r_rb) * AW'(r_k) + w_kk;
    assign w_b_raddr = AW'(r_cb) * AW'(r_k) + w_kk;

    assign w_a_word = (r_state == S_FEED) ? w_a_rdata : '0;
    assign w_b_word = (r_state == S_FEED) ? w_b_rdata : '0;

    tpu_gbuff #(.DEPTH(GBUFF_DEPTH), .W(WORD_W), .AW(AW)) GBUFF_A (
        .clk(clk), .i_we(1'b0), .i_waddr('0), .i_wdata('0),
        .i_raddr(w_a_raddr), .o_rdata(w_a_rdata)
    );
    tpu_gbuff #(.DEPTH(GBUFF_DEPTH), .W(WORD_W), .AW(AW)) GBUFF_B (
        .clk(clk), .i_we(1'b0), .i_waddr('0), .i_wdata('0),
        .i_raddr(w_b_raddr), .o_rdata(w_b_rdata)
    );
    tpu_gbuff #(.DEPTH(GBUFF_DEPTH), .W(WORD_W), .AW(AW)) GBUFF_OUT (
        .clk(clk), .i_we(w_out_we), .i_waddr(w_out_waddr), .i_wdata(w_out_wdata),
        .i_raddr('0), .o_rdata(w_out_rdata)
    );
    assign w_unused_rd = ^w_out_rdata;

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (m == 4'd0 || k == 4'd0 || n == 4'd0) ? S_DONE : S_LOAD;
            S_LOAD:  w_next = S_FEED;
            S_FEED:  if (r_cnt == r_k - 4'd1) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == 4'(2 * ARRAY - 2)) w_next = S_WRITE;
            S_WRITE: if (w_last_row) w_next = w_last_tile ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_m     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_rb    <= '0;
            r_cb    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_m  <= m;
                r_k  <= k;
                r_n  <= n;
                r_rb <= '0;
                r_cb <= '0;
            end
            if (r_state == S_WRITE && w_last_row && !w_last_tile) begin
                // cb is the inner tile loop, rb the outer.
                if (AW'(r_cb) + AW'(1) < w_nb) begin
                    r_cb <= r_cb + 4'd1;
                end else begin
                    r_cb <= '0;
                    r_rb <= r_rb + 4'd1;
                end
            end
            if (w_next != r_state) r_cnt <= '0;
            else if (r_state == S_FEED || r_state == S_DRAIN || r_state == S_WRITE)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    // Systolic operand routing. Row i of A and column j of B enter i resp. j
    // cycles late, so A[i][t] and B[t][j] meet in PE(i,j) at cycle t+i+j.
    always_comb begin
        for (int i = 0; i < ARRAY; i++) begin
            for (int j = 0; j < ARRAY; j++) begin
                if (j == 0)
                    w_a_in[i][j] = (i == 0) ? w_a_word[DATA_W-1:0] : r_a_skew[i][(i == 0) ? 0 : i - 1];
                else
                    w_a_in[i][j] = r_a_pipe[i][(j == 0) ? 0 : j - 1];
                if (i == 0)
                    w_b_in[i][j] = (j == 0) ? w_b_word[DATA_W-1:0] : r_b_skew[j][(j == 0) ? 0 : j - 1];
                else
                    w_b_in[i][j] = r_b_pipe[(i == 0) ? 0 : i - 1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARRAY; i++) begin
                for (int j = 0; j < ARRAY; j++) begin
                    r_a_skew[i][j] <= '0;
                    r_b_skew[i][j] <= '0;
                    r_a_pipe[i][j] <= '0;
                    r_b_pipe[i][j] <= '0;
                    r_acc[i][j]    <= '0;
                end
            end
        end else begin
            for (int i = 0; i < ARRAY; i++) begin
                r_a_skew[i][0] <= w_a_word[i*DATA_W +: DATA_W];
                r_b_skew[i][0] <= w_b_word[i*DATA_W +: DATA_W];
                for (int d = 1; d < ARRAY; d++) begin
                    r_a_skew[i][d] <= r_a_skew[i][d-1];
                    r_b_skew[i][d] <= r_b_skew[i][d-1];
                end
                for (int j = 0; j < ARRAY; j++) begin
                    r_a_pipe[i][j] <= w_a_in[i][j];
                    r_b_pipe[i][j] <= w_b_in[i][j];
                    if (r_state == S_LOAD)
                        r_acc[i][j] <= '0;
                    else if (r_state == S_FEED || r_state == S_DRAIN)
                        r_acc[i][j] <= r_acc[i][j] + ACC_W'(w_a_in[i][j]) * ACC_W'(w_b_in[i][j]);
                end
            end
        end
    end

    // One OUT word per valid tile row; lanes past column n-1 are zeroed.
    assign w_out_we    = (r_state == S_WRITE) && (w_row < AW'(r_m));
    assign w_out_waddr = w_row * w_nb + AW'(r_cb);

    always_comb begin
        w_out_wdata = '0;
        for (int i = 0; i < ARRAY; i++) begin
            if (r_cnt == 4'(i)) begin
                for (int j = 0; j < ARRAY; j++) begin
                    if (w_col_base + AW'(j) < AW'(r_n))
                        w_out_wdata[j*DATA_W +: DATA_W] = r_acc[i][j][DATA_W-1:0];
                end
            end
        end
    end

    assign done        = r_done;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tpu_top.sv
module tb_tpu_top;
  localparam logic [31:0] SENTINEL = 32'hA5A5_A5A5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] m, k, n;
  logic       done;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int am [16][16];
  int bm [16][16];

  tpu_top dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n),
    .done(done), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    m = 4'd0; k = 4'd0; n = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: place am/bm into the buffers in tile layout, poison OUT
  task automatic preload(input int mm, input int kk, input int nn);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      dut.GBUFF_A.gbuff[i] = '0;
      dut.GBUFF_B.gbuff[i] = '0;
      dut.GBUFF_OUT.gbuff[i] = SENTINEL;
    end
    for (int rb = 0; rb < (mm + 3) / 4; rb++)
      for (int t = 0; t < kk; t++) begin
        w = '0;
        for (int j = 0; j < 4; j++)
          if (4 * rb + j < mm) w[8*j +: 8] = 8'(am[4*rb+j][t]);
        dut.GBUFF_A.gbuff[rb*kk+t] = w;
      end
    for (int cb = 0; cb < (nn + 3) / 4; cb++)
      for (int t = 0; t < kk; t++) begin
        w = '0;
        for (int j = 0; j < 4; j++)
          if (4 * cb + j < nn) w[8*j +: 8] = 8'(bm[t][4*cb+j]);
        dut.GBUFF_B.gbuff[cb*kk+t] = w;
      end
  endtask

  // driver: pulse start, wait (bounded) for done
  task automatic run(input int mm, input int kk, input int nn, output int cycles);
    @(negedge clk);
    m = 4'(mm); k = 4'(kk); n = 4'(nn);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 4'd0; k = 4'd0; n = 4'd0;  // only latched values may matter
    cycles = 1;
    while (done !== 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // scoreboard: reference matrix product packed into the OUT layout
  task automatic verify(input string tag, input int mm, input int kk, input int nn);
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int nb, c, acc;
    nb = (nn + 3) / 4;
    for (int r = 0; r < mm; r++)
      for (int cb = 0; cb < nb; cb++) begin
        e = '0;
        for (int j = 0; j < 4; j++) begin
          c = 4 * cb + j;
          if (c < nn) begin
            acc = 0;
            for (int t = 0; t < kk; t++) acc += am[r][t] * bm[t][c];
            e[8*j +: 8] = 8'(acc % 256);
          end
        end
        exp_q.push_back(e);
      end
    for (int a = 0; a < mm * nb; a++)
      check($sformatf("%s_out%0d", tag, a), dut.GBUFF_OUT.gbuff[a], exp_q.pop_front());
    check($sformatf("%s_untouched", tag), dut.GBUFF_OUT.gbuff[mm*nb], SENTINEL);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        am[i][j] = int'($urandom_range(0, 255));
        bm[i][j] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic setup_identity();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        am[i][j] = (i == j) ? 1 : 0;
        bm[i][j] = (i < 4 && j < 4) ? i * 4 + j + 1 : 0;
      end
  endtask

  initial begin
    int cyc, rm, rk, rn, waited;

    // reset state
    do_reset();
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);

    // 1: identity A, B = 1..16
    setup_identity();
    preload(4, 4, 4);
    run(4, 4, 4, cyc);
    verify("t1", 4, 4, 4);
    check("t1_word0", dut.GBUFF_OUT.gbuff[0], 32'h0403_0201);
    check("t1_word3", dut.GBUFF_OUT.gbuff[3], 32'h100F_0E0D);
    @(negedge clk);
    check("t1_done_held", {31'd0, done}, 32'd1);

    // 2: all ones, ragged dimensions
    do_reset();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin am[i][j] = 1; bm[i][j] = 1; end
    preload(2, 3, 5);
    run(2, 3, 5, cyc);
    verify("t2", 2, 3, 5);
    check("t2_word1", dut.GBUFF_OUT.gbuff[1], 32'h0000_0003);

    // 3: single element, latency bound
    do_reset();
    am[0][0] = 8'h0F; bm[0][0] = 8'h11;
    preload(1, 1, 1);
    run(1, 1, 1, cyc);
    check("t3_word0", dut.GBUFF_OUT.gbuff[0], 32'h0000_00FF);
    check("t3_latency_ok", {31'd0, cyc <= 20}, 32'd1);

    // 4: saturating operands, mod-256 wrap
    do_reset();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin am[i][j] = 255; bm[i][j] = 255; end
    preload(4, 4, 4);
    run(4, 4, 4, cyc);
    verify("t4", 4, 4, 4);
    check("t4_word2", dut.GBUFF_OUT.gbuff[2], 32'h0404_0404);

    // 5: multi-tile random data
    do_reset();
    fill_random();
    preload(8, 4, 12);
    run(8, 4, 12, cyc);
    verify("t5", 8, 4, 12);

    // random dimensions, including the 15x15x15 worst case
    for (int it = 0; it < 3; it++) begin
      do_reset();
      fill_random();
      rm = (it == 0) ? 15 : int'($urandom_range(1, 15));
      rk = (it == 0) ? 15 : int'($urandom_range(1, 15));
      rn = (it == 0) ? 15 : int'($urandom_range(1, 15));
      preload(rm, rk, rn);
      run(rm, rk, rn, cyc);
      verify($sformatf("rnd%0d", it), rm, rk, rn);
      check($sformatf("rnd%0d_latency", it), {31'd0, cyc < 1000}, 32'd1);
    end

    // zero dimension: straight to DONE, nothing written
    do_reset();
    preload(4, 4, 4);
    run(0, 4, 4, cyc);
    check("zero_no_write", dut.GBUFF_OUT.gbuff[0], SENTINEL);

    // 6: abort mid-FEED, then rerun test 1
    do_reset();
    setup_identity();
    preload(4, 4, 4);
    @(negedge clk);
    m = 4'd4; k = 4'd4; n = 4'd4;
    start = 1'b1;
    waited = 0;
    while (dbg_state !== 3'd2 && waited < 50) begin
      @(negedge clk);
      start = 1'b0;
      waited++;
    end
    check("t6_reached_feed", {29'd0, dbg_state}, 32'd2);
    rst = 1'b0;
    #1;
    check("t6_abort_done", {31'd0, done}, 32'd0);
    check("t6_abort_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    preload(4, 4, 4);
    run(4, 4, 4, cyc);
    verify("t6", 4, 4, 4);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
